// File: rtl/smoosh_pkg.sv
// rtl/smoosh_pkg.sv - shared constants and state type for the NES pad responder
package smoosh_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int FRAME_LEN = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } resp_state_e;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-flop synchronizer with registered rise/fall detect
// level_o is the delayed level, aligned with the registered edge pulses.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

  assign level_o = prev_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/nes_pad_responder.sv
// rtl/nes_pad_responder.sv - NES controller emulation: latch buttons, shift them out on host clock
module nes_pad_responder
  import smoosh_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 60000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       latch,
  input  logic       ctrl_clk,
  input  logic [7:0] buttons,
  output logic       data,
  output logic       busy,
  output logic       frame_done,
  output logic       short_frame
);

  localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);
  localparam logic [3:0]        CNT_LAST = 4'(FRAME_LEN - 1);

  logic latch_lvl, latch_rise, latch_fall;
  logic ck_lvl, ck_rise, ck_fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (latch),
    .level_o (latch_lvl),
    .rise_o  (latch_rise),
    .fall_o  (latch_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ctrl_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (ctrl_clk),
    .level_o (ck_lvl),
    .rise_o  (ck_rise),
    .fall_o  (ck_fall)
  );

  resp_state_e      state_q, state_d;
  logic [7:0]       sr_q, sr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             data_q, data_d;
  logic             fd_q, fd_d;
  logic             sf_q, sf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sr_q    <= 8'hFF;
      cnt_q   <= '0;
      tmo_q   <= '0;
      data_q  <= 1'b1;
      fd_q    <= 1'b0;
      sf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      fd_q    <= fd_d;
      sf_q    <= sf_d;
    end
  end

  // A high latch overrides everything, including a coincident shift edge.
  always_comb begin
    state_d = state_q;
    if (latch_lvl) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD:  if (latch_fall) state_d = ST_SHIFT;
        ST_SHIFT: begin
          if (ck_rise) begin
            if (cnt_q == CNT_LAST) state_d = ST_DONE;
          end else if (!ck_fall && tmo_q == TMO_LAST) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    tmo_d  = tmo_q;
    data_d = data_q;
    fd_d   = 1'b0;
    sf_d   = 1'b0;
    if (latch_lvl) begin
      sr_d   = ~buttons;
      data_d = ~buttons[BTN_A];
      cnt_d  = '0;
      tmo_d  = '0;
      sf_d   = (state_q == ST_SHIFT) && latch_rise;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (latch_fall) begin
            cnt_d  = '0;
            tmo_d  = '0;
            data_d = sr_q[0];
          end
        end
        ST_SHIFT: begin
          if (ck_rise) begin
            sr_d   = {1'b0, sr_q[7:1]};
            data_d = sr_q[1];
            cnt_d  = cnt_q + 4'd1;
            tmo_d  = '0;
            fd_d   = (cnt_q == CNT_LAST);
          end else if (ck_fall) begin
            tmo_d = '0;
          end else if (tmo_q == TMO_LAST) begin
            tmo_d  = '0;
            data_d = 1'b1;
            sf_d   = 1'b1;
          end else begin
            tmo_d = tmo_q + TMO_ONE;
          end
        end
        ST_DONE: data_d = 1'b0;
        default: data_d = 1'b1;
      endcase
    end
  end

  assign data        = data_q;
  assign busy        = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
  assign frame_done  = fd_q;
  assign short_frame = sf_q;

  logic unused_ok;
  assign unused_ok = ck_lvl;

endmodule

// File: tb/tb_nes_pad_responder.sv
// tb/tb_nes_pad_responder.sv - randomized and directed checks against a frame-level reference model
module tb_nes_pad_responder;

  localparam int SYNC = 2;
  localparam int TMO  = 100;

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_SHIFT = 2;
  localparam int M_DONE  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       latch = 1'b0;
  logic       ctrl_clk = 1'b0;
  logic [7:0] buttons = 8'h00;
  logic       data, busy, frame_done, short_frame;

  always #5 clk = ~clk;

  nes_pad_responder #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .latch       (latch),
    .ctrl_clk    (ctrl_clk),
    .buttons     (buttons),
    .data        (data),
    .busy        (busy),
    .frame_done  (frame_done),
    .short_frame (short_frame)
  );

  int checks = 0;
  int errors = 0;
  int fd_seen = 0;
  int sf_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Frame-level model: inputs take effect SYNC+1 edges after being sampled.
  int         m_mode, m_idx, m_idle;
  logic [7:0] m_btn;
  logic       e_data, e_busy, e_fd, e_sf;
  logic       lat_h [SYNC+3];
  logic       ck_h  [SYNC+3];

  task automatic model_reset();
    m_mode = M_IDLE; m_idx = 0; m_idle = 0; m_btn = 8'h00;
    e_data = 1'b1; e_busy = 1'b0; e_fd = 1'b0; e_sf = 1'b0;
    for (int j = 0; j < SYNC + 3; j++) begin
      lat_h[j] = 1'b0;
      ck_h[j]  = 1'b0;
    end
  endtask

  task automatic model_step(input logic l, input logic c, input logic [7:0] b);
    logic lcur, lprev, ccur, cprev;
    for (int j = SYNC + 2; j > 0; j--) begin
      lat_h[j] = lat_h[j-1];
      ck_h[j]  = ck_h[j-1];
    end
    lat_h[0] = l;
    ck_h[0]  = c;
    lcur = lat_h[SYNC+1]; lprev = lat_h[SYNC+2];
    ccur = ck_h[SYNC+1];  cprev = ck_h[SYNC+2];
    e_fd = 1'b0;
    e_sf = 1'b0;
    if (lcur) begin
      if (m_mode == M_SHIFT) e_sf = 1'b1;
      m_mode = M_LOAD;
      m_btn  = b;
      e_data = ~b[0];
    end else if (m_mode == M_LOAD) begin
      if (lprev) begin
        m_mode = M_SHIFT; m_idx = 0; m_idle = 0;
      end
    end else if (m_mode == M_SHIFT) begin
      if (ccur && !cprev) begin
        m_idx++;
        m_idle = 0;
        if (m_idx == 8) begin
          m_mode = M_DONE; e_fd = 1'b1; e_data = 1'b0;
        end else begin
          e_data = ~m_btn[m_idx];
        end
      end else if (!ccur && cprev) begin
        m_idle = 0;
      end else begin
        m_idle++;
        if (m_idle == TMO) begin
          m_mode = M_IDLE; e_data = 1'b1; e_sf = 1'b1;
        end
      end
    end else if (m_mode == M_DONE) begin
      e_data = 1'b0;
    end else begin
      e_data = 1'b1;
    end
    e_busy = (m_mode == M_LOAD) || (m_mode == M_SHIFT);
  endtask

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else model_step(latch, ctrl_clk, buttons);
    #1;
    chk("data", data, e_data);
    chk("busy", busy, e_busy);
    chk("frame_done", frame_done, e_fd);
    chk("short_frame", short_frame, e_sf);
    if (frame_done) fd_seen++;
    if (short_frame) sf_seen++;
  end

  task automatic pulse_latch(input int hi, input int gap);
    @(negedge clk) latch = 1'b1;
    repeat (hi) @(negedge clk);
    latch = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_ck(input int hi, input int lo);
    @(negedge clk) ctrl_clk = 1'b1;
    repeat (hi) @(negedge clk);
    ctrl_clk = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  int exp031 [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
  int exp032 [8] = '{0, 1, 1, 1, 1, 1, 0, 0};
  int fd0, sf0, lat, found;
  logic old;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_data", data, 1);
    chk("reset_busy", busy, 0);
    chk("reset_fd", frame_done, 0);
    chk("reset_sf", short_frame, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Shift clocks with no latch are ignored.
    fd0 = fd_seen; sf0 = sf_seen;
    repeat (3) pulse_ck(2, 3);
    chk("nolatch_data", data, 1);
    chk("nolatch_busy", busy, 0);
    chk("nolatch_pulses", (fd_seen - fd0) + (sf_seen - sf0), 0);

    // A pressed only.
    buttons = 8'h01;
    fd0 = fd_seen;
    pulse_latch(3, 6);
    chk("f1_bit0", data, 0);
    for (int i = 0; i < 8; i++) begin
      pulse_ck(3, 5);
      chk($sformatf("f1_shift%0d", i + 1), data, exp031[i]);
    end
    chk("f1_fd_count", fd_seen - fd0, 1);

    // B and Right pressed, extra shifts after the frame.
    buttons = 8'h82;
    fd0 = fd_seen;
    pulse_latch(3, 6);
    chk("f2_bit0", data, 1);
    for (int i = 0; i < 8; i++) begin
      pulse_ck(3, 5);
      chk($sformatf("f2_shift%0d", i + 1), data, exp032[i]);
    end
    pulse_ck(3, 5);
    pulse_ck(3, 5);
    chk("f2_extra_data", data, 0);
    chk("f2_fd_count", fd_seen - fd0, 1);

    // Edge-to-data latency on every shift (alternating pattern changes data each time).
    buttons = 8'h55;
    pulse_latch(3, 6);
    for (int i = 0; i < 8; i++) begin
      old = data;
      lat = -1;
      @(negedge clk) ctrl_clk = 1'b1;
      for (int k = 1; k <= 10; k++) begin
        @(posedge clk); #2;
        if (data !== old && lat < 0) lat = k - 1;
      end
      @(negedge clk) ctrl_clk = 1'b0;
      repeat (5) @(negedge clk);
      chk($sformatf("latency_shift%0d", i + 1), lat, SYNC + 1);
    end

    // Re-latch after 3 shifts: short frame, back in LOAD.
    buttons = 8'h3C;
    pulse_latch(3, 6);
    repeat (3) pulse_ck(3, 4);
    sf0 = sf_seen;
    buttons = 8'h0B;
    @(negedge clk) latch = 1'b1;
    repeat (8) @(negedge clk);
    chk("relatch_sf", sf_seen - sf0, 1);
    chk("relatch_busy", busy, 1);
    chk("relatch_data", data, 0);
    latch = 1'b0;
    repeat (6) @(negedge clk);

    // Timeout after 2 shifts.
    buttons = 8'h00;
    pulse_latch(3, 6);
    pulse_ck(3, 4);
    @(negedge clk) ctrl_clk = 1'b1;
    repeat (3) @(negedge clk);
    ctrl_clk = 1'b0;
    found = -1;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #2;
      if (short_frame && found < 0) begin
        found = k;
        chk("timeout_data", data, 1);
        chk("timeout_busy", busy, 0);
        break;
      end
    end
    chk("timeout_cycle", found, TMO + SYNC + 2);
    repeat (4) @(negedge clk);

    // Reset mid-frame after 4 shifts.
    buttons = 8'h00;
    pulse_latch(3, 6);
    repeat (4) pulse_ck(3, 4);
    sf0 = sf_seen;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_data", data, 1);
    chk("midreset_busy", busy, 0);
    chk("midreset_sf", short_frame, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) pulse_ck(3, 4);
    chk("postreset_data", data, 1);
    chk("postreset_busy", busy, 0);
    chk("postreset_sf", sf_seen - sf0, 0);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 11);
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk) buttons = 8'($urandom);
      end
      if (r <= 2) begin
        pulse_latch($urandom_range(1, 6), $urandom_range(0, 8));
      end else if (r <= 7) begin
        pulse_ck($urandom_range(1, 4), $urandom_range(1, 4));
      end else if (r == 8) begin
        @(negedge clk) begin latch = 1'b1; ctrl_clk = 1'b1; end
        repeat ($urandom_range(1, 4)) @(negedge clk);
        latch = 1'b0; ctrl_clk = 1'b0;
        repeat ($urandom_range(1, 6)) @(negedge clk);
      end else if (r == 9) begin
        repeat (TMO + 10) @(negedge clk);
      end else begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
      end
    end
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
